// File: rtl/fetch_pc.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack imem port and hands
// {pc, instr} to decode through a one-entry valid/ready buffer.
module fetch_pc #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr,
    input  logic               if_ready
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic                squash_q, squash_d;
    logic                req_q, req_d;
    logic                valid_q, valid_d;
    logic [ADDR_W-1:0]   if_pc_q, if_pc_d;
    logic [INSTR_W-1:0]  if_instr_q, if_instr_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        squash_d   = squash_q;
        req_d      = req_q;
        valid_d    = valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;

        case (state_q)
            IDLE: begin
                pc_d       = jump_en ? jump_target : pc_q;
                req_addr_d = pc_d;
                req_d      = 1'b1;
                state_d    = REQ;
            end

            REQ: begin
                if (!imem_ack) begin
                    // A jump while the request is in flight marks its data as dead;
                    // the request itself must stay untouched until acked.
                    if (jump_en) begin
                        pc_d     = jump_target;
                        squash_d = 1'b1;
                    end
                end else if (squash_q || jump_en) begin
                    squash_d   = 1'b0;
                    pc_d       = jump_en ? jump_target : pc_q;
                    req_addr_d = pc_d;
                end else begin
                    if_instr_d = imem_rdata;
                    if_pc_d    = req_addr_q;
                    valid_d    = 1'b1;
                    pc_d       = req_addr_q + ADDR_W'(1);
                    req_d      = 1'b0;
                    state_d    = HOLD;
                end
            end

            HOLD: begin
                // A jump drops the buffered instruction even if decode is ready.
                if (jump_en) begin
                    valid_d    = 1'b0;
                    pc_d       = jump_target;
                    req_addr_d = jump_target;
                    req_d      = 1'b1;
                    state_d    = REQ;
                end else if (if_ready) begin
                    valid_d    = 1'b0;
                    req_addr_d = pc_q;
                    req_d      = 1'b1;
                    state_d    = REQ;
                end
            end

            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            squash_q   <= 1'b0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            squash_q   <= squash_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = req_addr_q;
    assign if_valid  = valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;

endmodule

// File: tb/tb_fetch_pc.sv
// Bench for fetch_pc: directed scenarios plus a randomized run against a
// transaction-level model of what the fetch stage owes decode and imem.
`timescale 1ns/1ps
module tb_fetch_pc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        jump_en;
    logic [7:0]  jump_target;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        if_valid;
    logic [7:0]  if_pc;
    logic [15:0] if_instr;
    logic        if_ready;

    int total = 0;
    int bad   = 0;

    fetch_pc #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .jump_en(jump_en), .jump_target(jump_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .if_valid(if_valid), .if_pc(if_pc),
        .if_instr(if_instr), .if_ready(if_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return {a ^ 8'hC3, a};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; jump_en = 1'b0; jump_target = '0;
        imem_ack = 1'b0; imem_rdata = '0; if_ready = 1'b0;
        tick; tick;
        total++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== 8'h00 || if_instr !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got req=%b valid=%b pc=%h instr=%h, expected 0 0 00 0000",
                     imem_req, if_valid, if_pc, if_instr);
        end
        total++;
        if (imem_addr !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_addr: got %h expected 00", imem_addr);
        end
        rst_n = 1'b1;
        tick;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_first_req: got req=%b addr=%h expected 1 00", imem_req, imem_addr);
        end
    endtask

    task automatic test_stream;
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1; imem_rdata = 16'hA000 | 16'(i); if_ready = 1'b1;
            tick;
            total++;
            if (if_valid !== 1'b1 || if_pc !== 8'(i) || if_instr !== (16'hA000 | 16'(i)) || imem_req !== 1'b0) begin
                bad++;
                $display("[TB] FAIL stream_deliver[%0d]: got valid=%b pc=%h instr=%h req=%b expected 1 %h %h 0",
                         i, if_valid, if_pc, if_instr, imem_req, 8'(i), 16'hA000 | 16'(i));
            end
            imem_ack = 1'b0;
            tick;
            total++;
            if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'(i + 1)) begin
                bad++;
                $display("[TB] FAIL stream_next_req[%0d]: got valid=%b req=%b addr=%h expected 0 1 %h",
                         i, if_valid, imem_req, imem_addr, 8'(i + 1));
            end
        end
    endtask

    task automatic test_backpressure;
        if_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 16'hA003;
        tick;
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            total++;
            if (if_valid !== 1'b1 || if_pc !== 8'h03 || if_instr !== 16'hA003 || imem_req !== 1'b0) begin
                bad++;
                $display("[TB] FAIL backpressure_hold[%0d]: got valid=%b pc=%h instr=%h req=%b expected 1 03 A003 0",
                         i, if_valid, if_pc, if_instr, imem_req);
            end
        end
        if_ready = 1'b1;
        tick;
        total++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h04) begin
            bad++;
            $display("[TB] FAIL backpressure_release: got valid=%b req=%b addr=%h expected 0 1 04",
                     if_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_squash;
        imem_ack = 1'b1; imem_rdata = 16'hA004;
        tick;
        imem_ack = 1'b0;
        tick;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h05) begin
            bad++;
            $display("[TB] FAIL squash_setup: got req=%b addr=%h expected 1 05", imem_req, imem_addr);
        end
        jump_en = 1'b1; jump_target = 8'h40;
        tick;
        jump_en = 1'b0;
        tick;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h05 || if_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL squash_addr_stable: got req=%b addr=%h valid=%b expected 1 05 0",
                     imem_req, imem_addr, if_valid);
        end
        imem_ack = 1'b1; imem_rdata = 16'hA005;
        tick;
        total++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h40) begin
            bad++;
            $display("[TB] FAIL squash_drop: got valid=%b req=%b addr=%h expected 0 1 40",
                     if_valid, imem_req, imem_addr);
        end
        imem_rdata = 16'hA040;
        tick;
        imem_ack = 1'b0;
        total++;
        if (if_valid !== 1'b1 || if_pc !== 8'h40 || if_instr !== 16'hA040) begin
            bad++;
            $display("[TB] FAIL squash_target_data: got valid=%b pc=%h instr=%h expected 1 40 A040",
                     if_valid, if_pc, if_instr);
        end
        tick;
    endtask

    task automatic test_simultaneous;
        imem_ack = 1'b1; imem_rdata = 16'hA041; jump_en = 1'b1; jump_target = 8'h10;
        tick;
        jump_en = 1'b0;
        total++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h10) begin
            bad++;
            $display("[TB] FAIL ack_jump_drop: got valid=%b req=%b addr=%h expected 0 1 10",
                     if_valid, imem_req, imem_addr);
        end
        imem_rdata = 16'hA010;
        tick;
        imem_ack = 1'b0; jump_en = 1'b1; jump_target = 8'h20; if_ready = 1'b1;
        tick;
        jump_en = 1'b0;
        total++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h20) begin
            bad++;
            $display("[TB] FAIL hold_jump_drop: got valid=%b req=%b addr=%h expected 0 1 20",
                     if_valid, imem_req, imem_addr);
        end
        imem_ack = 1'b1; imem_rdata = 16'hA020;
        tick;
        imem_ack = 1'b0;
        tick;
    endtask

    task automatic test_wrap_and_reset;
        jump_en = 1'b1; jump_target = 8'hFF;
        tick;
        jump_en = 1'b0; imem_ack = 1'b1; imem_rdata = 16'hA021;
        tick;
        imem_rdata = 16'hA0FF;
        tick;
        imem_ack = 1'b0;
        total++;
        if (if_valid !== 1'b1 || if_pc !== 8'hFF || if_instr !== 16'hA0FF) begin
            bad++;
            $display("[TB] FAIL wrap_deliver: got valid=%b pc=%h instr=%h expected 1 FF A0FF",
                     if_valid, if_pc, if_instr);
        end
        tick;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            bad++;
            $display("[TB] FAIL wrap_next_addr: got req=%b addr=%h expected 1 00", imem_req, imem_addr);
        end
        jump_target = 8'h77;
        rst_n = 1'b0;
        tick;
        total++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midop_reset: got req=%b valid=%b expected 0 0", imem_req, if_valid);
        end
        rst_n = 1'b1;
        tick;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            bad++;
            $display("[TB] FAIL midop_restart: got req=%b addr=%h expected 1 00", imem_req, imem_addr);
        end
    endtask

    task automatic test_random;
        logic [7:0]  m_pc, buf_pc, exp_addr, p_addr, p_target;
        logic [15:0] buf_instr;
        logic        m_stale, p_req, p_valid, p_ack, p_jump, p_ready;
        logic        accepted, good, exp_valid, exp_req, chk_addr;
        int          wait_left;

        rst_n = 1'b0; jump_en = 1'b0; imem_ack = 1'b0; if_ready = 1'b0;
        tick;
        rst_n = 1'b1;
        m_pc = 8'h00; m_stale = 1'b0; buf_pc = '0; buf_instr = '0;
        wait_left = -1;

        for (int cyc = 0; cyc < 2000; cyc++) begin
            jump_en     = ($urandom_range(0, 9) == 0);
            jump_target = 8'($urandom);
            if_ready    = ($urandom_range(0, 2) != 0);
            imem_ack    = 1'b0;
            if (imem_req) begin
                if (wait_left < 0) wait_left = $urandom_range(0, 3);
                if (wait_left == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                end else begin
                    wait_left--;
                end
            end
            p_req = imem_req; p_valid = if_valid; p_addr = imem_addr;
            p_ack = imem_ack; p_jump = jump_en; p_target = jump_target; p_ready = if_ready;

            tick;

            accepted = p_req && p_ack;
            good     = accepted && !m_stale && !p_jump;
            if (accepted) wait_left = -1;
            if (p_jump) m_pc = p_target;
            else if (good) m_pc = p_addr + 8'd1;
            if (accepted) m_stale = 1'b0;
            else if (p_jump && p_req) m_stale = 1'b1;

            // What the fetch stage owes after this edge, by event.
            chk_addr = 1'b1; exp_addr = m_pc;
            if (good) begin
                exp_valid = 1'b1; exp_req = 1'b0; chk_addr = 1'b0;
                buf_pc = p_addr; buf_instr = mem_word(p_addr);
            end else if (accepted) begin
                exp_valid = 1'b0; exp_req = 1'b1;
            end else if (p_valid) begin
                if (p_jump || p_ready) begin
                    exp_valid = 1'b0; exp_req = 1'b1;
                end else begin
                    exp_valid = 1'b1; exp_req = 1'b0; chk_addr = 1'b0;
                end
            end else if (p_req) begin
                exp_valid = 1'b0; exp_req = 1'b1; exp_addr = p_addr;
            end else begin
                exp_valid = 1'b0; exp_req = 1'b1;
            end

            total++;
            if (if_valid !== exp_valid || imem_req !== exp_req) begin
                bad++;
                $display("[TB] FAIL rand_handshake cyc=%0d: got valid=%b req=%b expected %b %b",
                         cyc, if_valid, imem_req, exp_valid, exp_req);
            end
            if (chk_addr) begin
                total++;
                if (imem_addr !== exp_addr) begin
                    bad++;
                    $display("[TB] FAIL rand_addr cyc=%0d: got %h expected %h", cyc, imem_addr, exp_addr);
                end
            end
            if (exp_valid) begin
                total++;
                if (if_pc !== buf_pc || if_instr !== buf_instr) begin
                    bad++;
                    $display("[TB] FAIL rand_data cyc=%0d: got pc=%h instr=%h expected %h %h",
                             cyc, if_pc, if_instr, buf_pc, buf_instr);
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_squash;
        test_simultaneous;
        test_wrap_and_reset;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
